// File: rtl/poly_tone_gen.sv
// Polyphonic 50% square-wave tone generator: shared octave register, per-voice period counters.
// Define OCTAVE_WRAP_EN to make the octave wrap around at either end instead of saturating.
module poly_tone_gen #(
   parameter  int NUM_VOICES = 4,
   parameter  int NUM_OCT    = 5,
   parameter  int MID_OCT    = 2,
   parameter  int DIV_W      = 18,
   localparam int OCT_W      = $clog2(NUM_OCT)
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic                    o_up,
   input  logic                    o_down,
   input  logic [4*NUM_VOICES-1:0] note_sel,
   input  logic [NUM_VOICES-1:0]   note_en,
   output logic [OCT_W-1:0]        octave,
   output logic [NUM_VOICES-1:0]   wave,
   output logic [NUM_VOICES-1:0]   voice_active
);
   localparam logic [OCT_W-1:0] OCT_MAX = OCT_W'(NUM_OCT - 1);
   localparam logic [OCT_W-1:0] OCT_MID = OCT_W'(MID_OCT);

   logic [OCT_W-1:0]      octave_q, octave_d;
   logic                  up_prev_q, up_prev_d;
   logic                  down_prev_q, down_prev_d;
   logic                  up_edge, down_edge;
   logic [DIV_W-1:0]      cnt_q [NUM_VOICES];
   logic [DIV_W-1:0]      cnt_d [NUM_VOICES];
   logic [NUM_VOICES-1:0] wave_q, wave_d;

   // Out-of-range notes fall back to the longest period so re-enabling a valid note wraps at once.
   function automatic logic [DIV_W-1:0] base_period(input logic [3:0] note);
      logic [DIV_W-1:0] p;
      case (note)
         4'd0:    p = DIV_W'(38223);
         4'd1:    p = DIV_W'(36077);
         4'd2:    p = DIV_W'(34052);
         4'd3:    p = DIV_W'(32141);
         4'd4:    p = DIV_W'(30337);
         4'd5:    p = DIV_W'(28635);
         4'd6:    p = DIV_W'(27027);
         4'd7:    p = DIV_W'(25511);
         4'd8:    p = DIV_W'(24079);
         4'd9:    p = DIV_W'(22727);
         4'd10:   p = DIV_W'(21452);
         4'd11:   p = DIV_W'(20248);
         default: p = DIV_W'(38223);
      endcase
      return p;
   endfunction

   function automatic logic [DIV_W-1:0] scale_period(input logic [DIV_W-1:0] base,
                                                      input logic [OCT_W-1:0] oct);
      if (oct >= OCT_MID) return base >> (oct - OCT_MID);
      else                return base << (OCT_MID - oct);
   endfunction

   always_comb begin
      up_edge     = o_up & ~up_prev_q;
      down_edge   = o_down & ~down_prev_q;
      up_prev_d   = o_up;
      down_prev_d = o_down;
      octave_d    = octave_q;
      if (up_edge && !down_edge) begin
         if (octave_q == OCT_MAX) begin
`ifdef OCTAVE_WRAP_EN
            octave_d = '0;
`else
            octave_d = OCT_MAX;
`endif
         end else begin
            octave_d = octave_q + 1'b1;
         end
      end else if (down_edge && !up_edge) begin
         if (octave_q == '0) begin
`ifdef OCTAVE_WRAP_EN
            octave_d = OCT_MAX;
`else
            octave_d = '0;
`endif
         end else begin
            octave_d = octave_q - 1'b1;
         end
      end
   end

   always_comb begin
      logic [DIV_W-1:0] div_v;
      logic [DIV_W-1:0] half_v;
      for (int v = 0; v < NUM_VOICES; v++) begin
         voice_active[v] = note_en[v] && (note_sel[4*v +: 4] < 4'd12);
         div_v           = scale_period(base_period(note_sel[4*v +: 4]), octave_q);
         half_v          = div_v >> 1;
         cnt_d[v]        = cnt_q[v] + 1'b1;
         wave_d[v]       = wave_q[v];
         if (!voice_active[v]) begin
            cnt_d[v]  = div_v - 1'b1;
            wave_d[v] = 1'b0;
         end else if (cnt_q[v] >= div_v - 1'b1) begin
            // >= rather than == so a period shortened mid-tone wraps immediately
            cnt_d[v]  = '0;
            wave_d[v] = 1'b1;
         end else if (cnt_d[v] == half_v) begin
            wave_d[v] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         octave_q    <= OCT_MID;
         up_prev_q   <= 1'b0;
         down_prev_q <= 1'b0;
         wave_q      <= '0;
         for (int v = 0; v < NUM_VOICES; v++) cnt_q[v] <= '0;
      end else begin
         octave_q    <= octave_d;
         up_prev_q   <= up_prev_d;
         down_prev_q <= down_prev_d;
         wave_q      <= wave_d;
         for (int v = 0; v < NUM_VOICES; v++) cnt_q[v] <= cnt_d[v];
      end
   end

   assign octave = octave_q;
   assign wave   = wave_q;
endmodule
